// File: rtl/fifo_tx_arbiter.sv
// fifo_tx_arbiter
//   Round-robin, frame-locked arbiter that lets N_REQ TX frame sources share
//   one byte FIFO. A source is granted for a whole frame. Each accepted byte
//   is written to the FIFO as {last, byte}. Frames longer than MAX_FRAME are
//   truncated: the MAX_FRAME-th byte is written with last forced high, and the
//   rest of the frame is accepted and discarded.
//
// Handshake: a byte moves from source g to the FIFO on a clock edge where
//   s_valid[g] && s_ready[g]. s_ready[g] never depends on s_valid[g]. The
//   source holds s_data/s_last stable until that transfer happens.
//
// Ports
//   clk          sole clock, posedge
//   rst          asynchronous active-low reset
//   req          per-source frame pending
//   s_data       per-source byte, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_valid      per-source byte valid
//   s_last       per-source last byte of frame
//   s_ready      per-source ready (only the granted bit can be high)
//   grant        registered one-hot owner, 0 when idle
//   fifo_wr_en   FIFO write strobe
//   fifo_din     {last, byte} write word
//   fifo_full    FIFO full
//   fifo_count   FIFO occupancy
//   frame_done   pulse on the write of a frame's last word
//   overflow     pulse when a frame is truncated at MAX_FRAME
//   busy         arbiter is not idle
//   state_dbg    current FSM state (0 idle, 1 transfer, 2 drain)
module fifo_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MIN_FREE   = 16,
    parameter int MAX_FRAME  = 1518
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [N_REQ-1:0]            s_valid,
    input  logic [N_REQ-1:0]            s_last,
    output logic [N_REQ-1:0]            s_ready,
    output logic [N_REQ-1:0]            grant,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH:0]         fifo_din,
    input  logic                        fifo_full,
    input  logic [ADDR_WIDTH:0]         fifo_count,
    output logic                        frame_done,
    output logic                        overflow,
    output logic                        busy,
    output logic [1:0]                  state_dbg
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LEN_W = $clog2(MAX_FRAME + 1);
    localparam int CNT_W = ADDR_WIDTH + 1;

    // free >= MIN_FREE rewritten as a bound on occupancy to avoid a subtraction
    localparam logic [ADDR_WIDTH:0] GATE_COUNT = CNT_W'(DEPTH - MIN_FREE);
    localparam logic [LEN_W-1:0]    LEN_LIMIT  = LEN_W'(MAX_FRAME - 1);
    localparam logic [LEN_W-1:0]    LEN_MAX    = LEN_W'(MAX_FRAME);
    localparam logic [N_REQ-1:0]    ONE_HOT_0  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [LEN_W-1:0]     len_cnt;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 space_ok;
    logic [DATA_WIDTH-1:0] g_data;
    logic                 g_valid;
    logic                 g_last;
    logic                 xfer_fire;
    logic                 drain_fire;
    logic                 at_limit;
    logic                 trunc;
    logic [IDX_W-1:0]     next_ptr;

    // First pending request at or after rr_ptr, wrapping around.
    always_comb begin : pick_blk
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign space_ok = (fifo_count <= GATE_COUNT);

    assign g_data  = s_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign g_valid = s_valid[grant_idx];
    assign g_last  = s_last[grant_idx];

    assign xfer_fire  = (state == XFER) && g_valid && !fifo_full;
    assign drain_fire = (state == DRAIN) && g_valid;
    // The byte now being transferred is number len_cnt+1.
    assign at_limit   = (len_cnt == LEN_LIMIT);
    assign trunc      = xfer_fire && !g_last && at_limit;

    assign next_ptr = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        s_ready = '0;
        if (state == XFER)
            s_ready = grant & {N_REQ{!fifo_full}};
        else if (state == DRAIN)
            s_ready = grant;
    end

    assign fifo_wr_en = xfer_fire;
    assign fifo_din   = xfer_fire ? {g_last | trunc, g_data} : '0;
    assign frame_done = xfer_fire && (g_last || at_limit);
    assign overflow   = trunc;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            len_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found && space_ok) begin
                        grant     <= ONE_HOT_0 << pick_idx;
                        grant_idx <= pick_idx;
                        len_cnt   <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_fire) begin
                        if (len_cnt != LEN_MAX) len_cnt <= len_cnt + 1'b1;
                        if (g_last) begin
                            rr_ptr <= next_ptr;
                            grant  <= '0;
                            state  <= IDLE;
                        end else if (at_limit) begin
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_fire && g_last) begin
                        rr_ptr <= next_ptr;
                        grant  <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
